io_supply_seq: RTL and testbench
================================

// Module: io_supply_seq
// PURPOSE
//  Parametrised power-up/power-down sequencer for N IO supply domains (VDDIO-class pad rings).
//  Enables each domain in order, qualifies its async power-good with sync+debounce+timeout,
//  then releases pad isolation. Monitors running domains and force-isolates all on a fault.
//  Sits in the always-on digital domain beside the IO supply pad cells.
// PARAMETERS
//  N_DOM    4     number of IO supply domains (1..16)
//  DEB_CYC  16    consecutive synced-stable cycles required to qualify power-good
//  TO_CYC   1024  max cycles waiting for power-good (up) or its loss (down)
//  CNT_W    11    counter width; must satisfy 2**CNT_W > max(DEB_CYC,TO_CYC)
// PORTS
//  clk        in   1              single clock
//  rst        in   1              asynchronous, active-high reset
//  start_i    in   1              level-sampled request to power up (from IDLE)
//  stop_i     in   1              request to power down / clear fault
//  pgood_i    in   N_DOM          async power-good per domain
//  sup_en_o   out  N_DOM          supply enable per domain
//  iso_o      out  N_DOM          pad isolation per domain, 1 = isolated
//  busy_o     out  1              sequencing in progress
//  done_o     out  1              all domains up and released
//  err_o      out  1              fault/timeout sticky flag
//  err_dom_o  out  $clog2(N_DOM)  index of domain that caused err_o (min width 1)
// BEHAVIOUR
//  Reset: sup_en_o=0, iso_o='1, busy_o=0, done_o=0, err_o=0, err_dom_o=0, FSM=IDLE, k=0.
//  Reset asserted mid-sequence forces these values immediately (async), regardless of state.
//  pgood_i: 2-FF sync per bit, then debounce: per-domain counter clears on synced-level change,
//   qualified level updates when counter reaches DEB_CYC-1 of stable synced value.
//  States: IDLE, EN, WAIT_PG, REL, UP, ISO, DIS, WAIT_OFF, FAULT. All outputs registered.
//  IDLE: start_i=1 & stop_i=0 -> EN, k=0, busy_o=1. start&stop same cycle: stop wins (stay IDLE).
//  EN: sup_en_o[k]<=1, timeout ctr<=0 -> WAIT_PG.
//  WAIT_PG: qualified pgood[k]=1 -> REL; ctr==TO_CYC-1 -> FAULT, err_dom_o<=k.
//  REL: iso_o[k]<=0; k==N_DOM-1 -> UP (done_o<=1, busy_o<=0) else k++ -> EN.
//  Latency: pgood_i[k] rising (stable) to iso_o[k] falling = DEB_CYC+4 cycles.
//  UP: any qualified pgood low -> FAULT, err_dom_o=lowest such index; stop_i -> ISO, k=N_DOM-1.
//  stop_i in EN/WAIT_PG/REL: power down from current k (k is the highest enabled domain) -> ISO.
//  ISO: iso_o[k]<=1, done_o<=0, busy_o<=1 -> DIS. DIS: sup_en_o[k]<=0, ctr<=0 -> WAIT_OFF.
//  WAIT_OFF: qualified pgood[k]=0 or ctr==TO_CYC-1 (timeout sets err_o, err_dom_o=k, continues);
//   k==0 -> IDLE (busy_o<=0) else k-- -> ISO. Down order strictly reverse of up order.
//  FAULT: same cycle of entry all iso_o<=1, all sup_en_o<=0, err_o<=1, done_o=0, busy_o=0;
//   stays until stop_i=1 -> IDLE, err_o cleared on that exit. start_i ignored in FAULT.
//  err_o otherwise sticky until next IDLE->EN transition (cleared there).
//  Invariant: iso_o[i]=0 implies sup_en_o[i]=1 in every cycle; assertion required.
// STRUCTURE
//  Package io_supply_seq_pkg: state enum seq_state_e, DEB/TO defaults, index width function.
//  Sub-module io_pg_sync_deb (one per domain via generate): 2-FF sync + debounce counter,
//   params DEB_CYC/CNT_W, out pg_q. Top holds FSM, k pointer, timeout ctr, output regs.
// TESTING  (N_DOM=4, DEB_CYC=4, TO_CYC=32 unless noted)
//  T1 start pulse, each pgood_i rises 5 cyc after its sup_en -> iso_o 1110,1100,1000,0000; done_o=1.
//  T2 pgood_i[2] never rises -> after 32 cyc in WAIT_PG: err_o=1, err_dom_o=2, sup_en_o=0, iso_o=1111.
//  T3 in UP, pgood_i[1] glitch low 2 cyc -> no fault; low 8 cyc -> FAULT, err_dom_o=1.
//  T4 stop_i in UP -> iso/sup_en drop order 3,2,1,0, each iso 1 cyc before sup_en; busy_o=0 at end.
//  T5 start_i&stop_i same cycle in IDLE -> no change; stop during WAIT_PG k=1 -> down 1,0 only.
//  T6 rst asserted mid WAIT_PG (async, between edges) -> outputs at reset values before next edge.

Source files
------------

// File: rtl/io_supply_seq_pkg.sv
// Shared types and defaults for the IO supply sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package io_supply_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    EN,
    WAIT_PG,
    REL,
    UP,
    ISO,
    DIS,
    WAIT_OFF,
    FAULT
  } seq_state_e;

  localparam int DEB_CYC_DEF = 16;
  localparam int TO_CYC_DEF  = 1024;
  localparam int CNT_W_DEF   = 11;

  // Width of a domain index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/io_pg_sync_deb.sv
// Power-good synchroniser (2 flops) followed by a stability debouncer.
// Latency: level change seen on edge 0 reaches pg_q on edge DEB_CYC+2.
// Backpressure: none; free-running qualifier of an async level.
module io_pg_sync_deb #(
  parameter int DEB_CYC = 16,
  parameter int CNT_W   = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic pg_i,
  output logic pg_q
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pg_d;

  // Shift the async level in; restart counting on any synced edge, adopt it once stable.
  always_comb begin
    sync_d = {sync_q[0], pg_i};
    last_d = sync_q[1];
    cnt_d  = cnt_q;
    pg_d   = pg_q;
    if (sync_q[1] != last_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      pg_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset reports power not good.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
      pg_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
      pg_q   <= pg_d;
    end
  end

endmodule

// File: rtl/io_supply_seq.sv
// Ordered power-up / reverse power-down of N IO supply domains with pad isolation and fault lockout.
// Latency: pgood_i[k] rising, seen on edge 0, releases iso_o[k] on edge DEB_CYC+4.
// Backpressure: none; start_i/stop_i are level-sampled, busy_o/done_o report progress.
module io_supply_seq
  import io_supply_seq_pkg::*;
#(
  parameter int N_DOM   = 4,
  parameter int DEB_CYC = DEB_CYC_DEF,
  parameter int TO_CYC  = TO_CYC_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [N_DOM-1:0]         pgood_i,
  output logic [N_DOM-1:0]         sup_en_o,
  output logic [N_DOM-1:0]         iso_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [idx_w(N_DOM)-1:0]  err_dom_o
);

  localparam int               IW      = idx_w(N_DOM);
  localparam logic [IW-1:0]    K_LAST  = IW'(N_DOM - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);

  seq_state_e       state_q, state_d;
  logic [IW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] ctr_q, ctr_d;
  logic [N_DOM-1:0] sup_en_q, sup_en_d;
  logic [N_DOM-1:0] iso_q, iso_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [IW-1:0]    err_dom_q, err_dom_d;

  logic [N_DOM-1:0] pg_qual;
  logic [IW-1:0]    low_idx;
  logic             enter_fault;

  for (genvar g = 0; g < N_DOM; g++) begin : g_pg
    io_pg_sync_deb #(
      .DEB_CYC (DEB_CYC),
      .CNT_W   (CNT_W)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .pg_i (pgood_i[g]),
      .pg_q (pg_qual[g])
    );
  end

  // Lowest-numbered running domain that has lost power-good (blamed on a fault).
  always_comb begin
    low_idx = '0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (!pg_qual[i]) low_idx = IW'(i);
    end
  end

  // Sequencer next state; a fault entry overrides every output in the same cycle.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ctr_d       = ctr_q;
    sup_en_d    = sup_en_q;
    iso_d       = iso_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    err_dom_d   = err_dom_q;
    enter_fault = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d = EN;
          k_d     = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      EN: begin
        if (stop_i) begin
          state_d = ISO;
        end else begin
          sup_en_d[k_q] = 1'b1;
          ctr_d         = '0;
          state_d       = WAIT_PG;
        end
      end
      WAIT_PG: begin
        if (stop_i) begin
          state_d = ISO;
        end else if (pg_qual[k_q]) begin
          state_d = REL;
        end else if (ctr_q == TO_LAST) begin
          state_d     = FAULT;
          err_dom_d   = k_q;
          enter_fault = 1'b1;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      REL: begin
        if (stop_i) begin
          state_d = ISO;
        end else begin
          iso_d[k_q] = 1'b0;
          if (k_q == K_LAST) begin
            state_d = UP;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = EN;
          end
        end
      end
      UP: begin
        if (pg_qual != '1) begin
          state_d     = FAULT;
          err_dom_d   = low_idx;
          enter_fault = 1'b1;
        end else if (stop_i) begin
          state_d = ISO;
          k_d     = K_LAST;
        end
      end
      ISO: begin
        iso_d[k_q] = 1'b1;
        done_d     = 1'b0;
        busy_d     = 1'b1;
        state_d    = DIS;
      end
      DIS: begin
        sup_en_d[k_q] = 1'b0;
        ctr_d         = '0;
        state_d       = WAIT_OFF;
      end
      WAIT_OFF: begin
        if (!pg_qual[k_q] || (ctr_q == TO_LAST)) begin
          // A supply that never reports off is flagged, but shutdown carries on.
          if (pg_qual[k_q]) begin
            err_d     = 1'b1;
            err_dom_d = k_q;
          end
          if (k_q == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            k_d     = k_q - 1'b1;
            state_d = ISO;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      FAULT: begin
        if (stop_i) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_fault) begin
      iso_d    = '1;
      sup_en_d = '0;
      err_d    = 1'b1;
      done_d   = 1'b0;
      busy_d   = 1'b0;
    end
  end

  // State and output registers; reset isolates every pad and drops every supply at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      ctr_q     <= '0;
      sup_en_q  <= '0;
      iso_q     <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ctr_q     <= ctr_d;
      sup_en_q  <= sup_en_d;
      iso_q     <= iso_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_dom_q <= err_dom_d;
    end
  end

  assign sup_en_o  = sup_en_q;
  assign iso_o     = iso_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign err_dom_o = err_dom_q;

  // A pad may only be out of isolation while its supply is enabled.
  a_iso_needs_supply : assert property (@(posedge clk) disable iff (rst)
    ((~iso_q & ~sup_en_q) == '0));

endmodule

// File: tb/tb_io_supply_seq.sv
// Self-checking bench: vector tables, hand sequences, and random power-good delays vs a timing model.
// Latency: model predicts every output per cycle from the debounce and timeout rules.
// Backpressure: n/a.
module tb_io_supply_seq;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int TO  = 32;
  localparam int CW  = 11;
  localparam int BIG = 1 << 28;

  logic         clk = 1'b0;
  logic         rst, start_i, stop_i;
  logic [N-1:0] pgood_i, sup_en_o, iso_o;
  logic         busy_o, done_o, err_o;
  logic [1:0]   err_dom_o;

  int errors = 0;
  int checks = 0;

  int dly   [N];
  int iso_t [N];
  int dis_t [N];
  int iso_x [N];
  int dis_x [N];
  int end_t;
  int end_x;

  typedef struct {
    logic start;
    logic stop;
    logic exp_busy;
    logic exp_en0;
  } idle_vec_t;

  typedef struct {
    int   len;
    logic exp_fault;
  } glitch_vec_t;

  idle_vec_t   idle_tab   [4];
  glitch_vec_t glitch_tab [5];

  always #5 clk = ~clk;

  io_supply_seq #(
    .N_DOM   (N),
    .DEB_CYC (DEB),
    .TO_CYC  (TO),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .pgood_i   (pgood_i),
    .sup_en_o  (sup_en_o),
    .iso_o     (iso_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .err_dom_o (err_dom_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    pgood_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Power-up from IDLE. The supply model raises pgood[k] dly[k] cycles after it sees sup_en[k].
  // Timing model: a level driven at a negedge is first sampled on the next edge and moves iso
  // DEB+4 edges after that; the next domain is enabled one cycle after release; a domain whose
  // power-good is not recognised within TO cycles of WAIT_PG faults at en+TO.
  task automatic run_up(input string tag);
    int en_exp [N];
    int fall_exp [N];
    int en_seen [N];
    int fault_cyc, fault_dom, end_cyc;
    logic [N-1:0] x_en, x_iso;
    logic x_flt;
    fault_cyc = -1;
    fault_dom = 0;
    for (int k = 0; k < N; k++) begin
      en_exp[k]   = BIG;
      fall_exp[k] = BIG;
      en_seen[k]  = -1;
    end
    en_exp[0] = 2;
    for (int k = 0; k < N; k++) begin
      if (fault_cyc < 0) begin
        if (dly[k] + DEB + 4 <= TO) begin
          fall_exp[k] = en_exp[k] + dly[k] + DEB + 5;
          if (k < N - 1) en_exp[k+1] = fall_exp[k] + 1;
        end else begin
          fault_cyc = en_exp[k] + TO;
          fault_dom = k;
        end
      end
    end
    end_cyc = (fault_cyc >= 0) ? fault_cyc : fall_exp[N-1];
    start_i = 1'b1;
    for (int cyc = 0; cyc <= end_cyc + 3; cyc++) begin
      if (cyc == 1) start_i = 1'b0;
      if (cyc >= 1) begin
        x_flt = (fault_cyc >= 0) && (cyc >= fault_cyc);
        for (int k = 0; k < N; k++) begin
          x_en[k]  = (cyc >= en_exp[k]) && !x_flt;
          x_iso[k] = !((cyc >= fall_exp[k]) && !x_flt);
        end
        check($sformatf("%s cyc%0d {en,iso,busy,done,err}", tag, cyc),
              {sup_en_o, iso_o, busy_o, done_o, err_o},
              {x_en, x_iso, (cyc < end_cyc), ((fault_cyc < 0) && (cyc >= fall_exp[N-1])), x_flt});
      end
      for (int k = 0; k < N; k++) begin
        if (sup_en_o[k] && en_seen[k] < 0) en_seen[k] = cyc;
        if (en_seen[k] >= 0 && cyc == en_seen[k] + dly[k]) pgood_i[k] = 1'b1;
      end
      @(negedge clk);
    end
    if (fault_cyc >= 0) check({tag, " err_dom"}, err_dom_o, fault_dom);
  endtask

  // Power-down by a one-cycle stop pulse; the supply model drops pgood as soon as sup_en falls.
  // Records the cycle each iso bit rises and each sup_en bit falls, and when busy goes low.
  task automatic run_down(input string tag, input int maxc);
    logic [N-1:0] iso_prev, en_prev;
    for (int i = 0; i < N; i++) begin
      iso_t[i] = -1;
      dis_t[i] = -1;
    end
    end_t    = -1;
    iso_prev = iso_o;
    en_prev  = sup_en_o;
    stop_i   = 1'b1;
    for (int cyc = 1; cyc <= maxc && end_t < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) stop_i = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (iso_o[i] && !iso_prev[i] && iso_t[i] < 0) iso_t[i] = cyc;
        if (!sup_en_o[i] && en_prev[i] && dis_t[i] < 0) begin
          dis_t[i]   = cyc;
          pgood_i[i] = 1'b0;
        end
      end
      iso_prev = iso_o;
      en_prev  = sup_en_o;
      if (cyc >= 3 && !busy_o) end_t = cyc;
    end
    check({tag, " reached idle"}, (end_t >= 0), 1'b1);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s iso%0d rise cyc", tag, i), iso_t[i], iso_x[i]);
      check($sformatf("%s sup_en%0d fall cyc", tag, i), dis_t[i], dis_x[i]);
    end
    check({tag, " idle cyc"}, end_t, end_x);
    check({tag, " final {en,iso,busy,done,err}"},
          {sup_en_o, iso_o, busy_o, done_o, err_o}, {4'h0, 4'hF, 3'b000});
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    idle_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    idle_tab[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
    idle_tab[2] = '{1'b1, 1'b1, 1'b0, 1'b0};
    idle_tab[3] = '{1'b1, 1'b0, 1'b1, 1'b1};
    glitch_tab[0] = '{1, 1'b0};
    glitch_tab[1] = '{2, 1'b0};
    glitch_tab[2] = '{DEB, 1'b0};
    glitch_tab[3] = '{DEB + 1, 1'b1};
    glitch_tab[4] = '{8, 1'b1};

    // Reset state
    do_reset();
    check("reset {en,iso,busy,done,err,dom}",
          {sup_en_o, iso_o, busy_o, done_o, err_o, err_dom_o}, {4'h0, 4'hF, 5'b0});

    // IDLE request decoding (stop beats start)
    for (int r = 0; r < 4; r++) begin
      do_reset();
      start_i = idle_tab[r].start;
      stop_i  = idle_tab[r].stop;
      @(negedge clk);
      start_i = 1'b0;
      stop_i  = 1'b0;
      check($sformatf("idle row%0d busy", r), busy_o, idle_tab[r].exp_busy);
      @(negedge clk);
      check($sformatf("idle row%0d {en,iso}", r), {sup_en_o, iso_o},
            {3'b000, idle_tab[r].exp_en0, 4'hF});
    end

    // T1: every pgood 5 cycles after its enable
    do_reset();
    for (int k = 0; k < N; k++) dly[k] = 5;
    run_up("T1 up");

    // T4: stop from UP, reverse order, iso one cycle ahead of sup_en
    iso_x[3] = 2;
    for (int i = N - 1; i >= 0; i--) begin
      if (i < N - 1) iso_x[i] = dis_x[i+1] + DEB + 5;
      dis_x[i] = iso_x[i] + 1;
    end
    end_x = dis_x[0] + DEB + 4;
    run_down("T4 down", 200);

    // Timeout boundary: slowest pgood that still qualifies on the last WAIT_PG cycle
    do_reset();
    dly[0] = TO - DEB - 4; dly[1] = 0; dly[2] = TO - DEB - 4; dly[3] = 1;
    run_up("TO edge pass");
    do_reset();
    dly[0] = 2; dly[1] = TO - DEB - 3; dly[2] = 2; dly[3] = 2;
    run_up("TO edge fail");

    // T2: pgood[2] never rises; then start is ignored and stop clears the fault
    do_reset();
    dly[0] = 5; dly[1] = 5; dly[2] = BIG; dly[3] = 5;
    run_up("T2 up");
    start_i = 1'b1;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    check("T2 start ignored in fault {en,busy,err}", {sup_en_o, busy_o, err_o}, {4'h0, 2'b01});
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    check("T2 stop clears fault {busy,err,done}", {busy_o, err_o, done_o}, 3'b000);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("T2 restart from idle busy", busy_o, 1'b1);

    // T3: glitches on pgood[1] while UP
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int k = 0; k < N; k++) dly[k] = 3;
      run_up($sformatf("T3 row%0d up", r));
      pgood_i[1] = 1'b0;
      for (int cyc = 0; cyc <= DEB + 10; cyc++) begin
        if (cyc == glitch_tab[r].len) pgood_i[1] = 1'b1;
        if (cyc >= 1) begin
          check($sformatf("T3 row%0d cyc%0d {err,done,en}", r, cyc),
                {err_o, done_o, sup_en_o},
                (glitch_tab[r].exp_fault && cyc >= DEB + 4) ? {2'b10, 4'h0} : {2'b01, 4'hF});
        end
        @(negedge clk);
      end
      if (glitch_tab[r].exp_fault) check($sformatf("T3 row%0d err_dom", r), err_dom_o, 2'd1);
    end

    // T5: stop while waiting on domain 1 powers down 1 then 0 only
    do_reset();
    begin : t5
      int s0;
      int c;
      s0 = -1;
      c  = 0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      while (!sup_en_o[1] && c < 100) begin
        if (sup_en_o[0] && s0 < 0) s0 = c;
        if (s0 >= 0 && c == s0 + 5) pgood_i[0] = 1'b1;
        @(negedge clk);
        c++;
      end
      repeat (3) @(negedge clk);
      check("T5 in WAIT_PG k=1 {en,iso,busy}", {sup_en_o, iso_o, busy_o}, {4'b0011, 4'b1110, 1'b1});
      iso_x[3] = -1; dis_x[3] = -1;
      iso_x[2] = -1; dis_x[2] = -1;
      iso_x[1] = -1; dis_x[1] = 3;
      iso_x[0] = 5;  dis_x[0] = 6;
      end_x = 6 + DEB + 4;
      run_down("T5 down", 100);
    end

    // Random power-good delays, some beyond the timeout
    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int k = 0; k < N; k++) dly[k] = $urandom_range(TO - DEB - 1, 0);
      run_up($sformatf("rand%0d", t));
    end

    // T6: asynchronous reset between edges during WAIT_PG
    do_reset();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int c = 0; c < 20 && !sup_en_o[0]; c++) @(negedge clk);
    check("T6 precondition en0", sup_en_o[0], 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("T6 async reset {en,iso,busy,done,err,dom}",
          {sup_en_o, iso_o, busy_o, done_o, err_o, err_dom_o}, {4'h0, 4'hF, 5'b0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("T6 idle after reset busy", busy_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
